rs_age_ordered: RTL and testbench

Parametrised reservation station for the out-of-order core, sitting between decode/rename and the ALU. It buffers up to DEPTH renamed ops and snoops NCDB result broadcast channels (ALU, LSB, ...) to wake pending operands. It issues the oldest ready op through a registered valid/ready port and supports a full flush on branch mispredict. This is the successor to the fixed 16-entry station, which had lowest-index issue, no backpressure and no flush.

---
 rtl/rs_age_ordered.sv | 204 ++++++++++++++++++++
 tb/tb_rs_age_ordered.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_age_ordered.sv
// Reservation station: age-matrix oldest-ready select, multi-channel CDB wakeup,
// allocate-time CDB bypass, registered valid/ready issue port and full flush.
module rs_age_ordered #(
  parameter int DEPTH = 16,
  parameter int XLEN  = 32,
  parameter int OPW   = 6,
  parameter int TAGW  = 4,
  parameter int NCDB  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  input  logic                        clear,
  input  logic                        in_valid,
  input  logic [OPW-1:0]              in_op,
  input  logic [TAGW-1:0]             in_rob,
  input  logic                        in_rs1_ready,
  input  logic                        in_rs2_ready,
  input  logic [XLEN-1:0]             in_rs1_val,
  input  logic [XLEN-1:0]             in_rs2_val,
  input  logic [TAGW-1:0]             in_rs1_tag,
  input  logic [TAGW-1:0]             in_rs2_tag,
  output logic                        rs_full,
  output logic [$clog2(DEPTH+1)-1:0]  rs_count,
  input  logic [NCDB-1:0]             cdb_valid,
  input  logic [NCDB*TAGW-1:0]        cdb_tag,
  input  logic [NCDB*XLEN-1:0]        cdb_val,
  output logic                        issue_valid,
  input  logic                        issue_ready,
  output logic [OPW-1:0]              issue_op,
  output logic [TAGW-1:0]             issue_rob,
  output logic [XLEN-1:0]             issue_rs1,
  output logic [XLEN-1:0]             issue_rs2
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Returns {hit, value}; scanning downward lets the lowest channel win.
  function automatic logic [XLEN:0] cdb_lookup(
    input logic [TAGW-1:0]      tag,
    input logic [NCDB-1:0]      vld,
    input logic [NCDB*TAGW-1:0] tags,
    input logic [NCDB*XLEN-1:0] vals
  );
    logic [XLEN:0] res;
    res = '0;
    for (int k = NCDB - 1; k >= 0; k--) begin
      if (vld[k] && (tags[k*TAGW +: TAGW] == tag)) begin
        res = {1'b1, vals[k*XLEN +: XLEN]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  logic [DEPTH-1:0] r_used;
  logic [DEPTH-1:0] r_r1;
  logic [DEPTH-1:0] r_r2;
  logic [OPW-1:0]   r_op  [DEPTH];
  logic [TAGW-1:0]  r_rob [DEPTH];
  logic [XLEN-1:0]  r_v1  [DEPTH];
  logic [XLEN-1:0]  r_v2  [DEPTH];
  logic [TAGW-1:0]  r_q1  [DEPTH];
  logic [TAGW-1:0]  r_q2  [DEPTH];
  logic [DEPTH-1:0] r_older [DEPTH];
  logic [CW-1:0]    r_count;

  logic             r_issue_valid;
  logic [OPW-1:0]   r_issue_op;
  logic [TAGW-1:0]  r_issue_rob;
  logic [XLEN-1:0]  r_issue_rs1;
  logic [XLEN-1:0]  r_issue_rs2;

  logic [XLEN:0]    w_m1 [DEPTH];
  logic [XLEN:0]    w_m2 [DEPTH];
  logic [XLEN:0]    w_b1;
  logic [XLEN:0]    w_b2;
  logic [DEPTH-1:0] w_cand;
  logic [DEPTH-1:0] w_sel_oh;
  logic [IW-1:0]    w_sel_idx;
  logic [IW-1:0]    w_free_idx;
  logic             w_load;
  logic             w_alloc;

  // Wakeup match of every entry's pending tags against the broadcast channels.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_m1[i] = cdb_lookup(r_q1[i], cdb_valid, cdb_tag, cdb_val);
      w_m2[i] = cdb_lookup(r_q2[i], cdb_valid, cdb_tag, cdb_val);
    end
  end

  assign w_b1   = cdb_lookup(in_rs1_tag, cdb_valid, cdb_tag, cdb_val);
  assign w_b2   = cdb_lookup(in_rs2_tag, cdb_valid, cdb_tag, cdb_val);
  assign w_cand = r_used & r_r1 & r_r2;

  // Oldest-ready select: a candidate wins if no other candidate is older.
  always_comb begin
    w_sel_oh  = '0;
    w_sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_sel_oh[i] = w_cand[i];
      for (int j = 0; j < DEPTH; j++) begin
        w_sel_oh[i] = w_sel_oh[i] & ~(w_cand[j] & r_older[j][i]);
      end
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_sel_idx = w_sel_oh[i] ? IW'(i) : w_sel_idx;
    end
  end

  // Lowest-index free slot for allocation.
  always_comb begin
    w_free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_free_idx = r_used[i] ? w_free_idx : IW'(i);
    end
  end

  assign rs_full = (r_count == CW'(DEPTH));
  assign w_load  = (|w_cand) && (!r_issue_valid || issue_ready);
  assign w_alloc = in_valid && !rs_full;

  // Entry array, age matrix, occupancy count and issue register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_used        <= '0;
      r_r1          <= '0;
      r_r2          <= '0;
      r_count       <= '0;
      r_issue_valid <= 1'b0;
      r_issue_op    <= '0;
      r_issue_rob   <= '0;
      r_issue_rs1   <= '0;
      r_issue_rs2   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_op[i]    <= '0;
        r_rob[i]   <= '0;
        r_v1[i]    <= '0;
        r_v2[i]    <= '0;
        r_q1[i]    <= '0;
        r_q2[i]    <= '0;
        r_older[i] <= '0;
      end
    end else if (rdy) begin
      if (clear) begin
        r_used        <= '0;
        r_count       <= '0;
        r_issue_valid <= 1'b0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_used[i] && !r_r1[i] && w_m1[i][XLEN]) begin
            r_v1[i] <= w_m1[i][XLEN-1:0];
            r_r1[i] <= 1'b1;
          end
          if (r_used[i] && !r_r2[i] && w_m2[i][XLEN]) begin
            r_v2[i] <= w_m2[i][XLEN-1:0];
            r_r2[i] <= 1'b1;
          end
        end

        if (w_load) begin
          r_used[w_sel_idx] <= 1'b0;
          r_issue_valid     <= 1'b1;
          r_issue_op        <= r_op[w_sel_idx];
          r_issue_rob       <= r_rob[w_sel_idx];
          r_issue_rs1       <= r_v1[w_sel_idx];
          r_issue_rs2       <= r_v2[w_sel_idx];
        end else if (issue_ready) begin
          r_issue_valid <= 1'b0;
        end

        // New entry is younger than every currently occupied one.
        if (w_alloc) begin
          r_used[w_free_idx]  <= 1'b1;
          r_op[w_free_idx]    <= in_op;
          r_rob[w_free_idx]   <= in_rob;
          r_q1[w_free_idx]    <= in_rs1_tag;
          r_q2[w_free_idx]    <= in_rs2_tag;
          r_r1[w_free_idx]    <= in_rs1_ready | w_b1[XLEN];
          r_r2[w_free_idx]    <= in_rs2_ready | w_b2[XLEN];
          r_v1[w_free_idx]    <= (in_rs1_ready || !w_b1[XLEN]) ? in_rs1_val : w_b1[XLEN-1:0];
          r_v2[w_free_idx]    <= (in_rs2_ready || !w_b2[XLEN]) ? in_rs2_val : w_b2[XLEN-1:0];
          r_older[w_free_idx] <= '0;
          for (int j = 0; j < DEPTH; j++) begin
            r_older[j][w_free_idx] <= r_used[j];
          end
        end

        r_count <= r_count + CW'(w_alloc) - CW'(w_load);
      end
    end
  end

  assign rs_count    = r_count;
  assign issue_valid = r_issue_valid;
  assign issue_op    = r_issue_op;
  assign issue_rob   = r_issue_rob;
  assign issue_rs1   = r_issue_rs1;
  assign issue_rs2   = r_issue_rs2;

endmodule

// File: tb/tb_rs_age_ordered.sv
// Bench for rs_age_ordered: directed scenarios plus random traffic, all checked
// every cycle against an age-ordered queue model of the station.
module tb_rs_age_ordered;

  localparam int DEPTH = 16;
  localparam int XLEN  = 32;
  localparam int OPW   = 6;
  localparam int TAGW  = 4;
  localparam int NCDB  = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic                clk;
  logic                rst, rdy, clear, in_valid;
  logic [OPW-1:0]      in_op;
  logic [TAGW-1:0]     in_rob, in_rs1_tag, in_rs2_tag;
  logic                in_rs1_ready, in_rs2_ready;
  logic [XLEN-1:0]     in_rs1_val, in_rs2_val;
  logic                rs_full;
  logic [CW-1:0]       rs_count;
  logic [NCDB-1:0]     cdb_valid;
  logic [NCDB*TAGW-1:0] cdb_tag;
  logic [NCDB*XLEN-1:0] cdb_val;
  logic                issue_valid, issue_ready;
  logic [OPW-1:0]      issue_op;
  logic [TAGW-1:0]     issue_rob;
  logic [XLEN-1:0]     issue_rs1, issue_rs2;

  rs_age_ordered #(.DEPTH(DEPTH), .XLEN(XLEN), .OPW(OPW), .TAGW(TAGW), .NCDB(NCDB)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .in_valid(in_valid),
    .in_op(in_op), .in_rob(in_rob), .in_rs1_ready(in_rs1_ready), .in_rs2_ready(in_rs2_ready),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_rs1_tag(in_rs1_tag), .in_rs2_tag(in_rs2_tag),
    .rs_full(rs_full), .rs_count(rs_count), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op), .issue_rob(issue_rob),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [OPW-1:0]  op;
    logic [TAGW-1:0] rob;
    logic [XLEN-1:0] v1, v2;
    logic [TAGW-1:0] q1, q2;
    bit              r1, r2;
  } ent_t;

  ent_t            mq[$];   // oldest at index 0
  bit              m_iv;
  logic [OPW-1:0]  m_op;
  logic [TAGW-1:0] m_rob;
  logic [XLEN-1:0] m_rs1, m_rs2;
  int              n_vec, n_err;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_cdb(input logic [TAGW-1:0] t, output logic [XLEN-1:0] v);
    v = '0;
    for (int k = 0; k < NCDB; k++) begin
      if (cdb_valid[k] && cdb_tag[k*TAGW +: TAGW] == t) begin
        v = cdb_val[k*XLEN +: XLEN];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic model_step();
    int sel;
    bit full, load, hit;
    logic [XLEN-1:0] v;
    ent_t s, e;
    if (!rst) begin
      mq.delete();
      m_iv = 0; m_op = '0; m_rob = '0; m_rs1 = '0; m_rs2 = '0;
    end else if (!rdy) begin
      // frozen
    end else if (clear) begin
      mq.delete();
      m_iv = 0;
    end else begin
      full = (mq.size() == DEPTH);
      sel = -1;
      for (int i = 0; i < mq.size(); i++) begin
        if (mq[i].r1 && mq[i].r2) begin sel = i; break; end
      end
      load = (sel >= 0) && (!m_iv || issue_ready);
      if (load) s = mq[sel];
      foreach (mq[i]) begin
        if (!mq[i].r1) begin hit = m_cdb(mq[i].q1, v); if (hit) begin mq[i].r1 = 1; mq[i].v1 = v; end end
        if (!mq[i].r2) begin hit = m_cdb(mq[i].q2, v); if (hit) begin mq[i].r2 = 1; mq[i].v2 = v; end end
      end
      if (load) begin
        mq.delete(sel);
        m_iv = 1; m_op = s.op; m_rob = s.rob; m_rs1 = s.v1; m_rs2 = s.v2;
      end else if (issue_ready) begin
        m_iv = 0;
      end
      if (in_valid && !full) begin
        e.op = in_op; e.rob = in_rob; e.q1 = in_rs1_tag; e.q2 = in_rs2_tag;
        e.r1 = in_rs1_ready; e.v1 = in_rs1_val;
        e.r2 = in_rs2_ready; e.v2 = in_rs2_val;
        if (!e.r1) begin hit = m_cdb(in_rs1_tag, v); if (hit) begin e.r1 = 1; e.v1 = v; end end
        if (!e.r2) begin hit = m_cdb(in_rs2_tag, v); if (hit) begin e.r2 = 1; e.v2 = v; end end
        mq.push_back(e);
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_eq("issue_valid", 64'(issue_valid), 64'(m_iv));
    check_eq("rs_count", 64'(rs_count), 64'(mq.size()));
    check_eq("rs_full", 64'(rs_full), 64'(mq.size() == DEPTH));
    check_eq("issue_op", 64'(issue_op), 64'(m_op));
    check_eq("issue_rob", 64'(issue_rob), 64'(m_rob));
    check_eq("issue_rs1", 64'(issue_rs1), 64'(m_rs1));
    check_eq("issue_rs2", 64'(issue_rs2), 64'(m_rs2));
  endtask

  task automatic idle();
    rst = 1'b1; rdy = 1'b1; clear = 1'b0; in_valid = 1'b0; cdb_valid = '0;
  endtask

  task automatic alloc(input logic [OPW-1:0] op, input logic [TAGW-1:0] rob,
                       input logic r1, input logic [XLEN-1:0] v1, input logic [TAGW-1:0] t1,
                       input logic r2, input logic [XLEN-1:0] v2, input logic [TAGW-1:0] t2);
    in_valid = 1'b1; in_op = op; in_rob = rob;
    in_rs1_ready = r1; in_rs1_val = v1; in_rs1_tag = t1;
    in_rs2_ready = r2; in_rs2_val = v2; in_rs2_tag = t2;
  endtask

  task automatic drain();
    idle();
    issue_ready = 1'b1;
    repeat (DEPTH + 4) cycle();
  endtask

  task automatic rand_phase(input int n, input int ready_pct, input int alloc_pct);
    for (int c = 0; c < n; c++) begin
      rst   = ($urandom_range(0, 299) != 0);
      rdy   = ($urandom_range(0, 7) != 0);
      clear = ($urandom_range(0, 63) == 0);
      in_valid     = ($urandom_range(0, 99) < alloc_pct);
      in_op        = OPW'($urandom);
      in_rob       = TAGW'($urandom);
      in_rs1_ready = $urandom_range(0, 1) == 1;
      in_rs2_ready = $urandom_range(0, 1) == 1;
      in_rs1_val   = $urandom;
      in_rs2_val   = $urandom;
      in_rs1_tag   = TAGW'($urandom);
      in_rs2_tag   = TAGW'($urandom);
      for (int k = 0; k < NCDB; k++) begin
        cdb_valid[k]              = $urandom_range(0, 1) == 1;
        cdb_tag[k*TAGW +: TAGW]   = TAGW'($urandom);
        cdb_val[k*XLEN +: XLEN]   = $urandom;
      end
      issue_ready = ($urandom_range(0, 99) < ready_pct);
      cycle();
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    idle();
    issue_ready = 1'b0;
    alloc('0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
    in_valid = 1'b0;
    cdb_tag = '0; cdb_val = '0;
    rst = 1'b0;
    cycle(); cycle();
    check_eq("reset_valid", 64'(issue_valid), 64'd0);
    check_eq("reset_count", 64'(rs_count), 64'd0);
    check_eq("reset_full", 64'(rs_full), 64'd0);
    check_eq("reset_rs1", 64'(issue_rs1), 64'd0);

    // Oldest-first: A waits on tag 3, B ready; B must issue before A.
    drain();
    alloc(6'd1, 4'd1, 1'b0, 32'd0, 4'd3, 1'b1, 32'd7, 4'd0);  cycle();
    alloc(6'd2, 4'd2, 1'b1, 32'd10, 4'd0, 1'b1, 32'd20, 4'd0); cycle();
    idle(); cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd3}; cdb_val = {32'd0, 32'hDEADBEEF}; cycle();
    check_eq("oldest_first_b", 64'(issue_rob), 64'd2);
    idle(); cycle();
    check_eq("oldest_first_a", 64'(issue_rob), 64'd1);
    check_eq("oldest_first_rs1", 64'(issue_rs1), 64'hDEADBEEF);

    // Two channels waking both operands in one cycle.
    drain();
    alloc(6'd3, 4'd4, 1'b0, 32'd0, 4'd5, 1'b0, 32'd0, 4'd7); cycle();
    idle(); cdb_valid = 2'b11; cdb_tag = {4'd7, 4'd5}; cdb_val = {32'h22, 32'h11}; cycle();
    idle(); cycle();
    check_eq("dual_cdb_valid", 64'(issue_valid), 64'd1);
    check_eq("dual_cdb_rs1", 64'(issue_rs1), 64'h11);
    check_eq("dual_cdb_rs2", 64'(issue_rs2), 64'h22);

    // Allocate-time bypass on rs2 from channel 1.
    drain();
    alloc(6'd4, 4'd6, 1'b1, 32'd1, 4'd0, 1'b0, 32'd0, 4'd9);
    cdb_valid = 2'b10; cdb_tag = {4'd9, 4'd0}; cdb_val = {32'h55, 32'h0}; cycle();
    idle(); cycle();
    check_eq("bypass_rob", 64'(issue_rob), 64'd6);
    check_eq("bypass_rs2", 64'(issue_rs2), 64'h55);

    // Backpressure then back-to-back issue.
    drain();
    issue_ready = 1'b0;
    for (int i = 10; i < 13; i++) begin
      alloc(OPW'(i), TAGW'(i), 1'b1, XLEN'(i), 4'd0, 1'b1, XLEN'(i + 100), 4'd0);
      cycle();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("bp_hold_rob", 64'(issue_rob), 64'd10);
      check_eq("bp_hold_count", 64'(rs_count), 64'd2);
    end
    issue_ready = 1'b1;
    cycle(); check_eq("b2b_first", 64'(issue_rob), 64'd11);
    cycle(); check_eq("b2b_second", 64'(issue_rob), 64'd12);
    cycle(); check_eq("b2b_empty", 64'(issue_valid), 64'd0);

    // Fill past capacity with the issue port stalled.
    drain();
    issue_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      alloc(OPW'(i), TAGW'(i), 1'b1, XLEN'(i), 4'd0, 1'b1, XLEN'(i), 4'd0);
      cycle();
    end
    check_eq("fill_full", 64'(rs_full), 64'd1);
    check_eq("fill_count", 64'(rs_count), 64'(DEPTH));

    // Flush with a colliding allocate, then a frozen allocate.
    clear = 1'b1; cycle();
    check_eq("flush_valid", 64'(issue_valid), 64'd0);
    check_eq("flush_count", 64'(rs_count), 64'd0);
    clear = 1'b0; rdy = 1'b0; in_valid = 1'b1; cycle();
    check_eq("freeze_count", 64'(rs_count), 64'd0);
    idle(); cycle();
    check_eq("after_freeze_count", 64'(rs_count), 64'd0);

    rand_phase(1500, 70, 60);
    rand_phase(800, 20, 90);
    rand_phase(800, 95, 40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
